// File: rtl/rs_issue_select_pkg.sv
// Shared sizing, entry record and helpers for the ALU reservation-station select stage.
package rs_issue_select_pkg;

  localparam int RS_DEPTH = 8;
  localparam int TAG_W    = 5;
  localparam int DLY_LEN  = 4;
  localparam int RS_IDX_W = $clog2(RS_DEPTH);

  // Cycles an issued entry stays busy after its issue_vld cycle (1..2^DLY_LEN-1).
  localparam logic [DLY_LEN-1:0] RELEASE_DLY = DLY_LEN'(2);

  typedef struct packed {
    logic               busy;
    logic               issued;
    logic [TAG_W-1:0]   tag;
    logic [DLY_LEN-1:0] lat;
    logic [DLY_LEN-1:0] cnt;
  } rs_entry_t;

  // Index of the lowest clear bit; 0 when every bit is set.
  function automatic logic [RS_IDX_W-1:0] lowest_zero(input logic [RS_DEPTH-1:0] v);
    logic [RS_IDX_W-1:0] idx;
    idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!v[i]) idx = RS_IDX_W'(i);
      else       idx = idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rs_issue_select_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter
  import rs_issue_select_pkg::*;
(
  input  logic [RS_DEPTH-1:0] req,
  input  logic [RS_IDX_W-1:0] ptr,
  output logic                gnt_any,
  output logic [RS_DEPTH-1:0] gnt_oh,
  output logic [RS_IDX_W-1:0] gnt_idx
);

  logic [RS_DEPTH-1:0] rot_s;
  logic [RS_IDX_W-1:0] off_s;

  // Rotate so ptr lands on bit 0, pick the lowest set bit, rotate the index back.
  always_comb begin
    rot_s = '0;
    off_s = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      rot_s[i] = req[RS_IDX_W'(RS_IDX_W'(i) + ptr)];
    end
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (rot_s[i]) off_s = RS_IDX_W'(i);
      else          off_s = off_s;
    end
    gnt_any = |req;
    gnt_idx = off_s + ptr;
    if (gnt_any) gnt_oh = RS_DEPTH'(1) << gnt_idx;
    else         gnt_oh = '0;
  end

endmodule

// File: rtl/rs_issue_select.sv
// Select/issue stage for the 8-entry ALU RS: entry state, RR grant, issue broadcast, timed release.
// Optional RS_REPLAY_EN adds replay_vld/replay_idx to pull an issued entry back into arbitration.
module rs_issue_select
  import rs_issue_select_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                alloc_vld,
  input  logic [TAG_W-1:0]    alloc_tag,
  input  logic [DLY_LEN-1:0]  alloc_lat,
  output logic                alloc_rdy,
  output logic [RS_IDX_W-1:0] alloc_idx,
  input  logic [RS_DEPTH-1:0] req_i,
  output logic [RS_DEPTH-1:0] busy_o,
  output logic [RS_DEPTH-1:0] issued_o,
  input  logic                fu_rdy,
`ifdef RS_REPLAY_EN
  input  logic                replay_vld,
  input  logic [RS_IDX_W-1:0] replay_idx,
`endif
  output logic                issue_vld,
  output logic [RS_IDX_W-1:0] issue_idx,
  output logic [TAG_W-1:0]    issue_tag,
  output logic [DLY_LEN-1:0]  issue_delay
);

  rs_entry_t           entries_r [RS_DEPTH];
  logic [RS_IDX_W-1:0] rr_ptr_r;
  logic [RS_DEPTH-1:0] busy_s, issued_s, cand_s, gnt_oh_s, replay_hit_s;
  logic [RS_IDX_W-1:0] gnt_idx_s;
  logic                gnt_any_s, grant_s, alloc_s;

  // Flatten entry flags for the wake-up interface and arbitration.
  always_comb begin
    busy_s   = '0;
    issued_s = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      busy_s[i]   = entries_r[i].busy;
      issued_s[i] = entries_r[i].issued;
    end
  end

  assign busy_o    = busy_s;
  assign issued_o  = issued_s;
  assign alloc_rdy = ~&busy_s;
  assign alloc_idx = lowest_zero(busy_s);
  assign alloc_s   = alloc_vld & alloc_rdy;
  assign cand_s    = req_i & busy_s & ~issued_s;

  rr_arbiter u_arb (
    .req     (cand_s),
    .ptr     (rr_ptr_r),
    .gnt_any (gnt_any_s),
    .gnt_oh  (gnt_oh_s),
    .gnt_idx (gnt_idx_s)
  );

  // Qualify the grant; a replay aimed at the granted slot suppresses it.
  always_comb begin
    replay_hit_s = '0;
    grant_s      = fu_rdy & gnt_any_s;
`ifdef RS_REPLAY_EN
    for (int i = 0; i < RS_DEPTH; i++) begin
      replay_hit_s[i] = replay_vld && (replay_idx == RS_IDX_W'(i)) && busy_s[i] &&
                        issued_s[i] && (entries_r[i].cnt != '0);
    end
    if (replay_vld && (replay_idx == gnt_idx_s)) grant_s = 1'b0;
    else                                         grant_s = grant_s;
`endif
  end

  // Per-entry state: alloc, grant, release countdown, replay, flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_DEPTH; i++) entries_r[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        entries_r[i].busy   <= 1'b0;
        entries_r[i].issued <= 1'b0;
        entries_r[i].cnt    <= '0;
      end
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (replay_hit_s[i]) begin
          entries_r[i].issued <= 1'b0;
          entries_r[i].cnt    <= '0;
        end else if (grant_s && gnt_oh_s[i]) begin
          entries_r[i].issued <= 1'b1;
          entries_r[i].cnt    <= RELEASE_DLY;
        end else if (entries_r[i].issued) begin
          if (entries_r[i].cnt == DLY_LEN'(1)) begin
            entries_r[i].busy   <= 1'b0;
            entries_r[i].issued <= 1'b0;
            entries_r[i].cnt    <= '0;
          end else begin
            entries_r[i].cnt <= entries_r[i].cnt - DLY_LEN'(1);
          end
        end else if (alloc_s && (alloc_idx == RS_IDX_W'(i))) begin
          entries_r[i].busy   <= 1'b1;
          entries_r[i].issued <= 1'b0;
          entries_r[i].tag    <= alloc_tag;
          entries_r[i].lat    <= alloc_lat;
          entries_r[i].cnt    <= '0;
        end
      end
    end
  end

  // Issue broadcast registers and round-robin pointer; payload holds when no grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_vld   <= 1'b0;
      issue_idx   <= '0;
      issue_tag   <= '0;
      issue_delay <= '0;
      rr_ptr_r    <= '0;
    end else if (flush) begin
      issue_vld <= 1'b0;
    end else if (grant_s) begin
      issue_vld   <= 1'b1;
      issue_idx   <= gnt_idx_s;
      issue_tag   <= entries_r[gnt_idx_s].tag;
      issue_delay <= entries_r[gnt_idx_s].lat;
      rr_ptr_r    <= gnt_idx_s + RS_IDX_W'(1);
    end else begin
      issue_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_issue_select.sv
// Self-checking bench for rs_issue_select: directed scenarios plus randomized traffic vs a reference model.
module tb_rs_issue_select;

  localparam int N  = 8;
  localparam int RD = 2;

  logic       clk = 1'b0;
  logic       rst_n, flush, alloc_vld, fu_rdy;
  logic [4:0] alloc_tag;
  logic [3:0] alloc_lat;
  logic       alloc_rdy;
  logic [2:0] alloc_idx;
  logic [7:0] req_i, busy_o, issued_o;
  logic       issue_vld;
  logic [2:0] issue_idx;
  logic [4:0] issue_tag;
  logic [3:0] issue_delay;
`ifdef RS_REPLAY_EN
  logic       replay_vld;
  logic [2:0] replay_idx;
`endif

  logic [32:0] act_vec;
  assign act_vec = {busy_o, issued_o, issue_vld, issue_idx, issue_tag, issue_delay, alloc_rdy, alloc_idx};

  int tests = 0;
  int fails = 0;

  // Reference model: per-entry flags plus the absolute cycle at which an issued entry frees.
  bit m_busy[N];
  bit m_iss[N];
  int m_tag[N], m_lat[N], m_free[N];
  int m_rr, cyc;
  bit m_vld;
  int m_idx, m_otag, m_odly;

  rs_issue_select dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .alloc_vld(alloc_vld), .alloc_tag(alloc_tag),
    .alloc_lat(alloc_lat), .alloc_rdy(alloc_rdy), .alloc_idx(alloc_idx), .req_i(req_i),
    .busy_o(busy_o), .issued_o(issued_o), .fu_rdy(fu_rdy),
`ifdef RS_REPLAY_EN
    .replay_vld(replay_vld), .replay_idx(replay_idx),
`endif
    .issue_vld(issue_vld), .issue_idx(issue_idx), .issue_tag(issue_tag), .issue_delay(issue_delay)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_iss[i] = 0; m_tag[i] = 0; m_lat[i] = 0; m_free[i] = 0;
    end
    m_rr = 0; m_vld = 0; m_idx = 0; m_otag = 0; m_odly = 0;
  endtask

  function automatic int m_free_idx();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic logic [32:0] exp_vec();
    logic [7:0] b, s;
    int f;
    for (int i = 0; i < N; i++) begin b[i] = m_busy[i]; s[i] = m_iss[i]; end
    f = m_free_idx();
    return {b, s, m_vld, 3'(m_idx), 5'(m_otag), 4'(m_odly), (f >= 0), (f >= 0) ? 3'(f) : 3'd0};
  endfunction

  // One clock: model reacts to the inputs present at the rising edge, then wait to the falling edge.
  task automatic step();
    int a, g, rp;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (flush) begin
      for (int i = 0; i < N; i++) begin m_busy[i] = 0; m_iss[i] = 0; end
      m_vld = 0;
    end else begin
      a  = alloc_vld ? m_free_idx() : -1;
      g  = -1;
      rp = -1;
      if (fu_rdy)
        for (int k = 0; k < N; k++) begin
          int e;
          e = (m_rr + k) % N;
          if (g < 0 && req_i[e] && m_busy[e] && !m_iss[e]) g = e;
        end
`ifdef RS_REPLAY_EN
      if (replay_vld) begin
        if (g == int'(replay_idx)) g = -1;
        if (m_busy[replay_idx] && m_iss[replay_idx]) rp = int'(replay_idx);
      end
`endif
      for (int i = 0; i < N; i++) begin
        if (i == rp) m_iss[i] = 0;
        else if (m_iss[i] && m_free[i] == cyc) begin m_busy[i] = 0; m_iss[i] = 0; end
      end
      if (a >= 0) begin
        m_busy[a] = 1; m_iss[a] = 0; m_tag[a] = alloc_tag; m_lat[a] = alloc_lat;
      end
      if (g >= 0) begin
        m_iss[g] = 1; m_free[g] = cyc + RD; m_rr = (g + 1) % N;
        m_vld = 1; m_idx = g; m_otag = m_tag[g]; m_odly = m_lat[g];
      end else begin
        m_vld = 0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 0; alloc_vld = 0; req_i = 8'h00; fu_rdy = 0;
`ifdef RS_REPLAY_EN
    replay_vld = 0; replay_idx = 3'd0;
`endif
  endtask

  task automatic test_reset();
    idle_inputs(); alloc_tag = 5'd0; alloc_lat = 4'd0; rst_n = 0;
    #1;
    tests++; if (act_vec !== 33'h8) begin fails++; $display("FAIL reset_async: got %h expected %h", act_vec, 33'h8); end
    model_reset();
    step(); step();
    rst_n = 1;
    tests++; if (act_vec !== exp_vec()) begin fails++; $display("FAIL reset_state: got %h expected %h", act_vec, exp_vec()); end
  endtask

  task automatic test_alloc();
    for (int k = 0; k < 3; k++) begin
      alloc_vld = 1; alloc_tag = 5'(5 + k); alloc_lat = 4'(k + 1);
      tests++; if (alloc_idx !== 3'(k)) begin fails++; $display("FAIL alloc_idx[%0d]: got %0d expected %0d", k, alloc_idx, k); end
      step();
    end
    alloc_vld = 0;
    tests++; if (busy_o !== 8'h07 || alloc_rdy !== 1'b1) begin fails++; $display("FAIL alloc_busy: got %h/%b expected 07/1", busy_o, alloc_rdy); end
    tests++; if (act_vec !== exp_vec()) begin fails++; $display("FAIL alloc_model: got %h expected %h", act_vec, exp_vec()); end
  endtask

  task automatic test_issue();
    req_i = 8'h07; fu_rdy = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (issue_vld !== 1'b1 || issue_idx !== 3'(k) || issue_tag !== 5'(5 + k) || issue_delay !== 4'(k + 1)) begin
        fails++; $display("FAIL issue[%0d]: got v%b i%0d t%0d d%0d expected v1 i%0d t%0d d%0d", k, issue_vld, issue_idx, issue_tag, issue_delay, k, 5 + k, k + 1);
      end
      tests++; if (busy_o[0] !== (k < 2)) begin fails++; $display("FAIL release0[%0d]: got %b expected %b", k, busy_o[0], k < 2); end
    end
    req_i = 8'h00; fu_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (act_vec !== exp_vec()) begin fails++; $display("FAIL issue_drain[%0d]: got %h expected %h", k, act_vec, exp_vec()); end
    end
    tests++; if (busy_o !== 8'h00 || issue_vld !== 1'b0) begin fails++; $display("FAIL issue_idle: got %h/%b expected 00/0", busy_o, issue_vld); end
  endtask

  task automatic test_fill();
    alloc_vld = 1;
    for (int k = 0; k < N; k++) begin
      alloc_tag = 5'($urandom_range(0, 31)); alloc_lat = 4'($urandom_range(1, 15));
      tests++; if (alloc_idx !== 3'(k)) begin fails++; $display("FAIL fill_idx[%0d]: got %0d expected %0d", k, alloc_idx, k); end
      step();
    end
    tests++; if (alloc_rdy !== 1'b0 || alloc_idx !== 3'd0 || busy_o !== 8'hFF) begin fails++; $display("FAIL full: got rdy%b idx%0d busy%h expected rdy0 idx0 busyff", alloc_rdy, alloc_idx, busy_o); end
    alloc_tag = 5'd31; step();
    alloc_vld = 0;
    tests++; if (act_vec !== exp_vec()) begin fails++; $display("FAIL full_ignore: got %h expected %h", act_vec, exp_vec()); end
  endtask

  task automatic test_wrap();
    req_i = 8'h81; fu_rdy = 1;
    step();
    tests++; if (issue_vld !== 1'b1 || issue_idx !== 3'd7 || issue_tag !== 5'(m_tag[7])) begin fails++; $display("FAIL wrap_7: got v%b i%0d t%0d expected v1 i7 t%0d", issue_vld, issue_idx, issue_tag, m_tag[7]); end
    step();
    tests++; if (issue_vld !== 1'b1 || issue_idx !== 3'd0 || issue_tag !== 5'(m_tag[0])) begin fails++; $display("FAIL wrap_0: got v%b i%0d t%0d expected v1 i0 t%0d", issue_vld, issue_idx, issue_tag, m_tag[0]); end
    req_i = 8'h06; fu_rdy = 0;
    step();
    tests++; if (issue_vld !== 1'b0 || issue_idx !== 3'd0) begin fails++; $display("FAIL fu_stall: got v%b i%0d expected v0 i0", issue_vld, issue_idx); end
    fu_rdy = 1;
    step();
    tests++; if (issue_vld !== 1'b1 || issue_idx !== 3'd1) begin fails++; $display("FAIL rr_hold: got v%b i%0d expected v1 i1", issue_vld, issue_idx); end
    req_i = 8'h00; fu_rdy = 0;
    for (int k = 0; k < 3; k++) step();
    tests++; if (act_vec !== exp_vec()) begin fails++; $display("FAIL wrap_model: got %h expected %h", act_vec, exp_vec()); end
  endtask

  task automatic test_release_alloc();
    alloc_vld = 1;
    for (int k = 0; k < 3; k++) begin alloc_tag = 5'(20 + k); alloc_lat = 4'(3); step(); end
    tests++; if (busy_o !== 8'hFF) begin fails++; $display("FAIL refill: got %h expected ff", busy_o); end
    alloc_vld = 0; req_i = 8'h10; fu_rdy = 1;
    step();
    tests++; if (issue_idx !== 3'd4 || issue_vld !== 1'b1) begin fails++; $display("FAIL grant4: got v%b i%0d expected v1 i4", issue_vld, issue_idx); end
    req_i = 8'h00; fu_rdy = 0; alloc_vld = 1; alloc_tag = 5'd9; alloc_lat = 4'd9;
    step();
    tests++; if (alloc_rdy !== 1'b0 || busy_o !== 8'hFF) begin fails++; $display("FAIL rel_pending: got rdy%b busy%h expected rdy0 busyff", alloc_rdy, busy_o); end
    step();
    tests++; if (busy_o !== 8'hEF || alloc_rdy !== 1'b1 || alloc_idx !== 3'd4) begin fails++; $display("FAIL rel_alloc: got busy%h rdy%b idx%0d expected busyef rdy1 idx4", busy_o, alloc_rdy, alloc_idx); end
    step();
    alloc_vld = 0;
    tests++; if (busy_o !== 8'hFF || act_vec !== exp_vec()) begin fails++; $display("FAIL realloc4: got %h expected %h", act_vec, exp_vec()); end
  endtask

  task automatic test_flush_and_reset();
    flush = 1; req_i = 8'hFF; fu_rdy = 1; alloc_vld = 1;
    step();
    idle_inputs();
    tests++; if (busy_o !== 8'h00 || issued_o !== 8'h00 || issue_vld !== 1'b0) begin fails++; $display("FAIL flush: got busy%h iss%h v%b expected 00 00 0", busy_o, issued_o, issue_vld); end
    tests++; if (act_vec !== exp_vec()) begin fails++; $display("FAIL flush_model: got %h expected %h", act_vec, exp_vec()); end
    alloc_vld = 1; alloc_tag = 5'd12; alloc_lat = 4'd4; step(); step();
    alloc_vld = 0; req_i = 8'h03; fu_rdy = 1;
    step();
    tests++; if (issue_vld !== 1'b1) begin fails++; $display("FAIL pre_reset_issue: got %b expected 1", issue_vld); end
    rst_n = 0;
    #1;
    tests++; if (act_vec !== 33'h8) begin fails++; $display("FAIL mid_reset: got %h expected %h", act_vec, 33'h8); end
    model_reset();
    idle_inputs();
    step();
    rst_n = 1;
    for (int k = 0; k < 2; k++) begin
      step();
      tests++; if (issue_vld !== 1'b0 || act_vec !== exp_vec()) begin fails++; $display("FAIL post_reset[%0d]: got %h expected %h", k, act_vec, exp_vec()); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      flush     = ($urandom_range(0, 31) == 0);
      alloc_vld = $urandom_range(0, 1);
      alloc_tag = 5'($urandom);
      alloc_lat = 4'($urandom);
      req_i     = 8'($urandom);
      fu_rdy    = ($urandom_range(0, 3) != 0);
      step();
      tests++; if (act_vec !== exp_vec()) begin fails++; $display("FAIL random[%0d]: got %h expected %h", k, act_vec, exp_vec()); end
    end
    idle_inputs();
  endtask

`ifdef RS_REPLAY_EN
  task automatic test_replay();
    flush = 1; step(); idle_inputs();
    alloc_vld = 1; alloc_tag = 5'd17; alloc_lat = 4'd5;
    for (int k = 0; k < 3; k++) step();
    alloc_vld = 0; req_i = 8'h04; fu_rdy = 1;
    step();
    tests++; if (issue_vld !== 1'b1 || issue_idx !== 3'd2) begin fails++; $display("FAIL replay_issue: got v%b i%0d expected v1 i2", issue_vld, issue_idx); end
    fu_rdy = 0; replay_vld = 1; replay_idx = 3'd2;
    step();
    replay_vld = 0;
    tests++; if (issued_o[2] !== 1'b0 || busy_o[2] !== 1'b1) begin fails++; $display("FAIL replay_state: got iss%b busy%b expected iss0 busy1", issued_o[2], busy_o[2]); end
    fu_rdy = 1;
    step();
    tests++; if (issue_vld !== 1'b1 || issue_idx !== 3'd2 || act_vec !== exp_vec()) begin fails++; $display("FAIL replay_reissue: got %h expected %h", act_vec, exp_vec()); end
    idle_inputs();
  endtask
`endif

  initial begin
    cyc = 0;
    test_reset();
    test_alloc();
    test_issue();
    test_fill();
    test_wrap();
    test_release_alloc();
    test_flush_and_reset();
    test_random();
`ifdef RS_REPLAY_EN
    test_replay();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
